// File: rtl/paddle_draw_sequencer_pkg.sv
// Shared screen limits, paddle geometry defaults and sequencer state encoding
// for the paddle draw path.
package paddle_draw_sequencer_pkg;

   localparam int unsigned SCREEN_W      = 160;
   localparam int unsigned SCREEN_H      = 180;
   localparam int unsigned DEF_PADDLE_W  = 40;
   localparam int unsigned DEF_PADDLE_H  = 8;
   localparam logic [7:0]  DEF_RESET_X   = 8'd60;
   localparam logic [7:0]  DEF_RESET_Y   = 8'd167;
   localparam logic [23:0] DEF_BG_COLOUR = 24'h000000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ERASE,
      ST_CLR,
      ST_DRAW,
      ST_FLUSH,
      ST_DONE
   } state_e;

   // Screen coordinates wrap at 8 bits; callers keep rectangles on screen.
   function automatic logic [7:0] rect_offset(input logic [7:0] base,
                                              input logic [7:0] off);
      return base + off;
   endfunction

endpackage

// File: rtl/paddle_draw_sequencer_rect_fill_counter.sv
// Row-major x/y scan counter over a W x H rectangle; shared by paddle and
// ball erase sequencing.
module rect_fill_counter
   import paddle_draw_sequencer_pkg::*;
#(
   parameter int unsigned W  = DEF_PADDLE_W,
   parameter int unsigned H  = DEF_PADDLE_H,
   parameter int unsigned CW = 8
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          step,
   output logic [CW-1:0] cx,
   output logic [CW-1:0] cy,
   output logic          last
);

   logic [CW-1:0] cx_q, cx_d;
   logic [CW-1:0] cy_q, cy_d;
   logic          x_wrap;

   assign x_wrap = (cx_q == CW'(W - 1));
   assign last   = x_wrap && (cy_q == CW'(H - 1));
   assign cx     = cx_q;
   assign cy     = cy_q;

   always_comb begin
      cx_d = cx_q;
      cy_d = cy_q;
      if (start) begin
         cx_d = '0;
         cy_d = '0;
      end else if (step) begin
         if (x_wrap) begin
            cx_d = '0;
            cy_d = last ? '0 : cy_q + 1'b1;
         end else begin
            cx_d = cx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cx_q <= '0;
         cy_q <= '0;
      end else begin
         cx_q <= cx_d;
         cy_q <= cy_d;
      end
   end

endmodule

// File: rtl/paddle_draw_sequencer.sv
// Per-frame paddle redraw: erase the old rectangle, then stream the sprite
// drawer's pixels (colour re-aligned to the one-cycle memory) to the VGA plot port.
module paddle_draw_sequencer
   import paddle_draw_sequencer_pkg::*;
#(
   parameter int unsigned PADDLE_W  = DEF_PADDLE_W,
   parameter int unsigned PADDLE_H  = DEF_PADDLE_H,
   parameter logic [7:0]  RESET_X   = DEF_RESET_X,
   parameter logic [7:0]  RESET_Y   = DEF_RESET_Y,
   parameter logic [23:0] BG_COLOUR = DEF_BG_COLOUR
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic [7:0]  paddle_x,
   input  logic [7:0]  paddle_y,
   output logic        draw_en,
   output logic        draw_rst,
   input  logic        draw_end,
   input  logic [7:0]  draw_x_curr,
   input  logic [7:0]  draw_y_curr,
   input  logic [23:0] draw_colour,
   output logic [7:0]  vga_x,
   output logic [7:0]  vga_y,
   output logic [23:0] vga_colour,
   output logic        vga_plot,
   output logic        busy,
   output logic        done
);

   state_e      state_q, state_d;
   logic [7:0]  old_x_q, old_x_d, old_y_q, old_y_d;
   logic [7:0]  new_x_q, new_x_d, new_y_q, new_y_d;
   logic        drawn_q, drawn_d;
   logic        pending_q, pending_d;
   logic [7:0]  vga_x_q, vga_x_d, vga_y_q, vga_y_d;
   logic [23:0] colour_q, colour_d;
   logic        plot_q, plot_d;
   logic        pass_q, pass_d;
   logic        done_q, done_d;

   logic [7:0]  ex, ey;
   logic        erase_last;
   logic        trig;

   rect_fill_counter #(
      .W  (PADDLE_W),
      .H  (PADDLE_H),
      .CW (8)
   ) u_erase_cnt (
      .clk   (clk),
      .reset (reset),
      .start (state_q == ST_IDLE),
      .step  (state_q == ST_ERASE),
      .cx    (ex),
      .cy    (ey),
      .last  (erase_last)
   );

   assign trig     = frame_tick || pending_q;
   assign draw_en  = (state_q == ST_DRAW);
   assign draw_rst = (state_q == ST_CLR);
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign vga_x    = vga_x_q;
   assign vga_y    = vga_y_q;
   assign vga_plot = plot_q;
   // Sprite memory q lags its address by one cycle, exactly like the
   // registered coordinates, so the colour is passed straight through.
   assign vga_colour = pass_q ? draw_colour : colour_q;

   always_comb begin
      state_d   = state_q;
      old_x_d   = old_x_q;
      old_y_d   = old_y_q;
      new_x_d   = new_x_q;
      new_y_d   = new_y_q;
      drawn_d   = drawn_q;
      pending_d = pending_q;
      vga_x_d   = vga_x_q;
      vga_y_d   = vga_y_q;
      colour_d  = colour_q;
      plot_d    = 1'b0;
      pass_d    = (state_q == ST_DRAW);
      done_d    = (state_q == ST_DONE);

      if (state_q == ST_IDLE) begin
         pending_d = 1'b0;
      end else if (frame_tick) begin
         pending_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (trig) begin
               new_x_d = paddle_x;
               new_y_d = paddle_y;
               if (drawn_q && paddle_x == old_x_q && paddle_y == old_y_q) begin
                  state_d = ST_DONE;
               end else if (drawn_q) begin
                  state_d = ST_ERASE;
               end else begin
                  state_d = ST_CLR;
               end
            end
         end
         ST_ERASE: begin
            vga_x_d  = rect_offset(old_x_q, ex);
            vga_y_d  = rect_offset(old_y_q, ey);
            colour_d = BG_COLOUR;
            plot_d   = 1'b1;
            if (erase_last) begin
               state_d = ST_CLR;
            end
         end
         ST_CLR: begin
            state_d = ST_DRAW;
         end
         ST_DRAW: begin
            vga_x_d = draw_x_curr;
            vga_y_d = draw_y_curr;
            plot_d  = !draw_end;
            if (draw_end) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            old_x_d = new_x_q;
            old_y_d = new_y_q;
            drawn_d = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         old_x_q   <= RESET_X;
         old_y_q   <= RESET_Y;
         new_x_q   <= '0;
         new_y_q   <= '0;
         drawn_q   <= 1'b0;
         pending_q <= 1'b0;
         vga_x_q   <= '0;
         vga_y_q   <= '0;
         colour_q  <= '0;
         plot_q    <= 1'b0;
         pass_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         old_x_q   <= old_x_d;
         old_y_q   <= old_y_d;
         new_x_q   <= new_x_d;
         new_y_q   <= new_y_d;
         drawn_q   <= drawn_d;
         pending_q <= pending_d;
         vga_x_q   <= vga_x_d;
         vga_y_q   <= vga_y_d;
         colour_q  <= colour_d;
         plot_q    <= plot_d;
         pass_q    <= pass_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_paddle_draw_sequencer.sv
// Scoreboard bench for paddle_draw_sequencer with a behavioural sprite drawer
// and one-cycle-latency sprite memory.
module tb_paddle_draw_sequencer;
   import paddle_draw_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_tick = 1'b0;
   logic [7:0]  paddle_x = 8'd60;
   logic [7:0]  paddle_y = 8'd167;
   logic        draw_en, draw_rst, draw_end;
   logic [7:0]  draw_x_curr, draw_y_curr;
   logic [23:0] draw_colour;
   logic [7:0]  vga_x, vga_y;
   logic [23:0] vga_colour;
   logic        vga_plot, busy, done;

   always #5 clk = ~clk;

   paddle_draw_sequencer #(
      .PADDLE_W  (40),
      .PADDLE_H  (8),
      .RESET_X   (8'd60),
      .RESET_Y   (8'd167),
      .BG_COLOUR (24'h000000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .paddle_x    (paddle_x),
      .paddle_y    (paddle_y),
      .draw_en     (draw_en),
      .draw_rst    (draw_rst),
      .draw_end    (draw_end),
      .draw_x_curr (draw_x_curr),
      .draw_y_curr (draw_y_curr),
      .draw_colour (draw_colour),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .vga_colour  (vga_colour),
      .vga_plot    (vga_plot),
      .busy        (busy),
      .done        (done)
   );

   function automatic logic [23:0] pix(input logic [7:0] cx, input logic [7:0] cy);
      logic [7:0] r, g, b;
      r = cx * 8'd3 + 8'd1;
      g = cy * 8'd17 + 8'd2;
      b = cx ^ cy ^ 8'h5A;
      return {r, g, b};
   endfunction

   // Drawer model: latches its base on draw_rst, steps row-major while enabled,
   // raises a sticky end flag the cycle after the final address.
   logic [7:0] dcx = '0, dcy = '0, dbx = '0, dby = '0;
   logic       dend = 1'b0;
   always @(posedge clk) begin
      if (reset || draw_rst) begin
         dcx <= '0; dcy <= '0; dend <= 1'b0; dbx <= paddle_x; dby <= paddle_y;
      end else if (draw_en && !dend) begin
         if (dcx == 8'd39 && dcy == 8'd7) dend <= 1'b1;
         else if (dcx == 8'd39) begin dcx <= '0; dcy <= dcy + 8'd1; end
         else dcx <= dcx + 8'd1;
      end
      draw_colour <= pix(dcx, dcy);
   end
   assign draw_x_curr = dbx + dcx;
   assign draw_y_curr = dby + dcy;
   assign draw_end    = dend;

   typedef struct {
      logic [7:0]  x;
      logic [7:0]  y;
      logic [23:0] c;
      bit          erase;
   } plot_t;
   plot_t exp_q[$];

   int vectors = 0, miscompares = 0;
   int cyc = 0, plots = 0, done_cnt = 0, rst_cnt = 0, draw_seen = 0;
   int last_erase_cyc = 0, gap = -1, done_cyc = 0, low_run = 0, max_low = 0;
   bit prev_erase = 1'b0;
   logic [7:0] m_old_x, m_old_y;
   bit m_drawn;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (vga_plot) begin
         plot_t e;
         plots++;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_plot: got x=%0d y=%0d c=%06h, want no plot", vga_x, vga_y, vga_colour);
         end else begin
            e = exp_q.pop_front();
            if (vga_x !== e.x || vga_y !== e.y || vga_colour !== e.c) begin
               miscompares++;
               $display("FAIL plot: got x=%0d y=%0d c=%06h, want x=%0d y=%0d c=%06h",
                        vga_x, vga_y, vga_colour, e.x, e.y, e.c);
            end
            if (e.erase) last_erase_cyc = cyc;
            else begin
               if (prev_erase) gap = cyc - last_erase_cyc;
               draw_seen++;
            end
            prev_erase = e.erase;
         end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (draw_rst) rst_cnt++;
      if (!busy) low_run++;
      else begin
         if (low_run > max_low) max_low = low_run;
         low_run = 0;
      end
   end

   task automatic push_rect(input logic [7:0] bx, input logic [7:0] by, input bit erase);
      plot_t e;
      for (int unsigned j = 0; j < 8; j++) begin
         for (int unsigned i = 0; i < 40; i++) begin
            e.x = bx + 8'(i);
            e.y = by + 8'(j);
            e.c = erase ? 24'h000000 : pix(8'(i), 8'(j));
            e.erase = erase;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic expect_frame(input logic [7:0] nx, input logic [7:0] ny);
      if (m_drawn && nx == m_old_x && ny == m_old_y) return;
      if (m_drawn) push_rect(m_old_x, m_old_y, 1'b1);
      push_rect(nx, ny, 1'b0);
      m_old_x = nx; m_old_y = ny; m_drawn = 1'b1;
   endtask

   task automatic pulse_tick(output int tcyc);
      @(posedge clk); #1;
      frame_tick = 1'b1;
      tcyc = cyc;
      @(posedge clk); #1;
      frame_tick = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk); #1;
         if (done_cnt >= target) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (vga_plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got plot=%b busy=%b done=%b, want 0 0 0", vga_plot, busy, done);
      end
      vectors++;
      if (draw_en !== 1'b0 || draw_rst !== 1'b0 || vga_x !== 8'd0 || vga_y !== 8'd0 || vga_colour !== 24'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got en=%b rst=%b x=%0d y=%0d c=%06h, want all 0",
                  draw_en, draw_rst, vga_x, vga_y, vga_colour);
      end
      reset = 1'b0;
      m_old_x = 8'd60; m_old_y = 8'd167; m_drawn = 1'b0;
   endtask

   task automatic test_first_draw;
      int p0, r0, d0, t;
      bit ok;
      p0 = plots; r0 = rst_cnt; d0 = done_cnt;
      paddle_x = 8'd60;
      expect_frame(8'd60, 8'd167);
      pulse_tick(t);
      wait_done(d0 + 1, 2000, ok);
      repeat (10) @(negedge clk);
      #1;
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL first_done_timeout: got no done, want done"); end
      vectors++;
      if (plots - p0 != 320) begin miscompares++; $display("FAIL first_plots: got %0d want 320", plots - p0); end
      vectors++;
      if (rst_cnt - r0 != 1) begin miscompares++; $display("FAIL first_draw_rst: got %0d want 1", rst_cnt - r0); end
      vectors++;
      if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL first_done_count: got %0d want 1", done_cnt - d0); end
      vectors++;
      if (exp_q.size() != 0) begin miscompares++; $display("FAIL first_leftover: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_skip;
      int p0, r0, d0, t;
      bit ok;
      p0 = plots; r0 = rst_cnt; d0 = done_cnt;
      expect_frame(8'd60, 8'd167);
      pulse_tick(t);
      wait_done(d0 + 1, 50, ok);
      repeat (5) @(negedge clk);
      #1;
      vectors++;
      if (!ok || done_cyc - t != 2) begin
         miscompares++;
         $display("FAIL skip_done_latency: got %0d (seen=%0b) want 2", done_cyc - t, ok);
      end
      vectors++;
      if (plots != p0 || rst_cnt != r0) begin
         miscompares++;
         $display("FAIL skip_activity: got plots=%0d rst=%0d, want 0 0", plots - p0, rst_cnt - r0);
      end
   endtask

   task automatic test_move;
      int p0, r0, d0, t;
      bit ok;
      p0 = plots; r0 = rst_cnt; d0 = done_cnt; gap = -1;
      paddle_x = 8'd61;
      expect_frame(8'd61, 8'd167);
      pulse_tick(t);
      wait_done(d0 + 1, 3000, ok);
      repeat (5) @(negedge clk);
      #1;
      vectors++;
      if (!ok || plots - p0 != 640) begin
         miscompares++;
         $display("FAIL move_plots: got %0d (done=%0b) want 640", plots - p0, ok);
      end
      // Last erase pixel issues in the final ERASE cycle and shows one cycle
      // later; the first sprite pixel shows three cycles after that issue.
      vectors++;
      if (gap != 2) begin miscompares++; $display("FAIL move_gap: got %0d want 2", gap); end
      vectors++;
      if (rst_cnt - r0 != 1) begin miscompares++; $display("FAIL move_draw_rst: got %0d want 1", rst_cnt - r0); end
      vectors++;
      if (exp_q.size() != 0) begin miscompares++; $display("FAIL move_leftover: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back;
      int p0, d0, t, ds;
      bit ok, hit;
      p0 = plots; d0 = done_cnt;
      paddle_x = 8'd70;
      expect_frame(8'd70, 8'd167);
      pulse_tick(t);
      max_low = 0; low_run = 0;
      ds = draw_seen; hit = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk); #1;
         if (draw_seen - ds >= 10) begin hit = 1'b1; break; end
      end
      vectors++;
      if (!hit) begin miscompares++; $display("FAIL b2b_draw_start: got no DRAW plots, want 10"); end
      pulse_tick(t);
      @(posedge clk);
      pulse_tick(t);
      paddle_x = 8'd75;
      expect_frame(8'd75, 8'd167);
      wait_done(d0 + 2, 3000, ok);
      repeat (60) @(negedge clk);
      #1;
      vectors++;
      if (!ok || done_cnt - d0 != 2) begin
         miscompares++;
         $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0);
      end
      vectors++;
      if (max_low > 1) begin miscompares++; $display("FAIL b2b_idle_gap: got %0d want <=1", max_low); end
      vectors++;
      if (plots - p0 != 1280 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL b2b_plots: got %0d left=%0d, want 1280 left=0", plots - p0, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_draw;
      int p0, r0, d0, t, ds;
      bit ok, hit;
      paddle_x = 8'd80;
      expect_frame(8'd80, 8'd167);
      ds = draw_seen; hit = 1'b0;
      pulse_tick(t);
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk); #1;
         if (draw_seen - ds == 100) begin hit = 1'b1; break; end
      end
      reset = 1'b1;
      vectors++;
      if (!hit) begin miscompares++; $display("FAIL abort_reach: got %0d DRAW plots, want 100", draw_seen - ds); end
      @(posedge clk); #1;
      vectors++;
      if (vga_plot !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_plot: got plot=%b busy=%b, want 0 0", vga_plot, busy);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      m_old_x = 8'd60; m_old_y = 8'd167; m_drawn = 1'b0;
      p0 = plots;
      repeat (20) @(negedge clk);
      #1;
      vectors++;
      if (plots != p0) begin miscompares++; $display("FAIL abort_quiet: got %0d plots want 0", plots - p0); end
      p0 = plots; r0 = rst_cnt; d0 = done_cnt;
      paddle_x = 8'd85;
      expect_frame(8'd85, 8'd167);
      pulse_tick(t);
      wait_done(d0 + 1, 2000, ok);
      repeat (5) @(negedge clk);
      #1;
      vectors++;
      if (!ok || plots - p0 != 320 || rst_cnt - r0 != 1) begin
         miscompares++;
         $display("FAIL post_abort_draw: got plots=%0d rst=%0d, want 320 1", plots - p0, rst_cnt - r0);
      end
      vectors++;
      if (exp_q.size() != 0) begin miscompares++; $display("FAIL post_abort_leftover: got %0d want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_first_draw();
      test_skip();
      test_move();
      test_back_to_back();
      test_reset_mid_draw();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no completion, want finish");
      $fatal(1, "timeout");
   end

endmodule
